// File: rtl/sseg_pkg.sv
// Shared types and constants for the serial 7-segment display driver.
package sseg_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // Bits per frame and the width of the bit index that walks it.
    localparam int FRAME_BITS = 64;
    localparam int BIT_CNT_W  = 6;
    localparam int DIGITS     = 8;

    // Active-low segment patterns {dp,g,f,e,d,c,b,a} with the dp bit off.
    // Element n is the pattern for hex digit n (listed F down to 0).
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Every segment and the dp dark: used for the blink-off phase.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational decoder: one hex nibble plus its decimal point to an
// active-low segment byte {dp,g,f,e,d,c,b,a}.
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       point,
    output logic [7:0] seg
);

    // Table lookup for the segments; a lit point pulls the dp bit low.
    always_comb begin
        seg = {~point, SEG_TABLE[hex][6:0]};
    end

endmodule

// File: rtl/sseg_serial_driver.sv
// Encodes eight hex digits into a 64-bit segment frame and shifts it MSB
// first into external shift registers, finishing each frame with a latch
// strobe. All outputs are registered.
module sseg_serial_driver
    import sseg_pkg::*;
#(
    parameter int DIV     = 2,
    parameter int BLINK_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] hexs,
    input  logic [7:0]  points,
    input  logic [7:0]  les,
    input  logic        start,
    output logic        busy,
    output logic        seg_clk,
    output logic        seg_sout,
    output logic        seg_pen,
    output logic        seg_clrn
);

    // Phase counter is sized for DIV but never narrower than one bit.
    localparam int              PH_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);

    state_t                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [BIT_CNT_W-1:0]    bit_q, bit_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic                    busy_d, sclk_d, sout_d, pen_d;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    blink_phase;
    logic [DIGITS-1:0][7:0]  dec_byte;
    logic [FRAME_BITS-1:0]   load_frame;

    assign blink_phase = blink_cnt[BLINK_W-1];

    // Free-running blink counter; only a reset clears it, never a frame request.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block order.
        if (rst) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // One decoder per digit; digit i takes nibble hexs[4i+3:4i].
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        sseg_hex_decode u_dec (
            .hex   (hexs[4*i +: 4]),
            .point (points[i]),
            .seg   (dec_byte[i])
        );
    end

    // Frame candidate: byte 7 lands in [63:56]; a blinking digit is blanked
    // whole (dp included) during blink phase 1. It is captured only at the
    // end of LOAD, so the inputs and blink phase are sampled once per frame.
    always_comb begin
        load_frame = '1;
        for (int i = 0; i < DIGITS; i++) begin
            load_frame[8*i +: 8] = (les[i] && blink_phase) ? SEG_BLANK : dec_byte[i];
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        // NOTE: every target gets a hold value first, so no path through the
        // case leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        busy_d  = busy;
        sclk_d  = seg_clk;
        sout_d  = seg_sout;
        pen_d   = seg_pen;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end
            end

            ST_LOAD: begin
                state_d = ST_SHIFT;
                frame_d = load_frame;
                sout_d  = load_frame[FRAME_BITS-1];
                phase_d = '0;
                bit_d   = '0;
                sclk_d  = 1'b0;
            end

            ST_SHIFT: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (!seg_clk) begin
                        // End of low half: raise the shift clock, data already stable.
                        sclk_d = 1'b1;
                    end else begin
                        // End of high half: drop the clock and move to the next bit.
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_LATCH;
                            pen_d   = 1'b1;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            frame_d = {frame_q[FRAME_BITS-2:0], 1'b1};
                            sout_d  = frame_q[FRAME_BITS-2];
                        end
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            ST_LATCH: begin
                if (phase_q == PH_LAST) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    pen_d   = 1'b0;
                    busy_d  = 1'b0;
                    sout_d  = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers and registered outputs; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            bit_q    <= '0;
            // NOTE: the frame register is reset to all ones so the serial
            // line idles high; it is a plain register, not a memory array.
            frame_q  <= '1;
            busy     <= 1'b0;
            seg_clk  <= 1'b0;
            seg_sout <= 1'b1;
            seg_pen  <= 1'b0;
            seg_clrn <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            busy     <= busy_d;
            seg_clk  <= sclk_d;
            seg_sout <= sout_d;
            seg_pen  <= pen_d;
            seg_clrn <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sseg_serial_driver.sv
// Directed testbench for sseg_serial_driver with DIV=2 and BLINK_W=4.
module tb_sseg_serial_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] hexs;
    logic [7:0]  points;
    logic [7:0]  les;
    logic        start;
    logic        busy;
    logic        seg_clk;
    logic        seg_sout;
    logic        seg_pen;
    logic        seg_clrn;

    int n_checks = 0;
    int n_err    = 0;

    sseg_serial_driver #(
        .DIV     (2),
        .BLINK_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hexs     (hexs),
        .points   (points),
        .les      (les),
        .start    (start),
        .busy     (busy),
        .seg_clk  (seg_clk),
        .seg_sout (seg_sout),
        .seg_pen  (seg_pen),
        .seg_clrn (seg_clrn)
    );

    always #5 clk = ~clk;

    // Hard time limit in case a wait is somehow never satisfied.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one frame starting at the current negedge; index 0 is the LOAD cycle.
    task automatic do_frame(input logic [31:0] h, input logic [7:0] p, input logic [7:0] l,
                            input int repulse_at, output logic [63:0] bits, output int busy_n,
                            output int pen_n, output int pen_pulses, output int first_rise,
                            output logic sout1, output logic sclk1);
        int   idx;
        logic prev_clk;
        logic prev_pen;
        hexs   = h;
        points = p;
        les    = l;
        start  = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        bits       = '1;
        busy_n     = 0;
        pen_n      = 0;
        pen_pulses = 0;
        first_rise = -1;
        sout1      = 1'bx;
        sclk1      = 1'bx;
        prev_clk   = 1'b0;
        prev_pen   = 1'b0;
        idx        = 0;
        while (busy === 1'b1 && idx < 1000) begin
            busy_n++;
            if (idx == 1) begin
                sout1 = seg_sout;
                sclk1 = seg_clk;
            end
            if (!prev_clk && seg_clk) begin
                bits = {bits[62:0], seg_sout};
                if (first_rise < 0) first_rise = idx;
            end
            if (seg_pen) begin
                pen_n++;
                if (!prev_pen) pen_pulses++;
            end
            prev_clk = seg_clk;
            prev_pen = seg_pen;
            start    = (idx == repulse_at);
            idx++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Applies reset and releases it on a negedge; returns at that negedge.
    task automatic apply_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        hexs   = '0;
        points = '0;
        les    = '0;
        rst    = 1'b1;
        start  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (seg_clk !== 1'b0)  begin n_err++; $display("FAIL reset_seg_clk: got %b want 0", seg_clk); end
        n_checks++; if (seg_sout !== 1'b1) begin n_err++; $display("FAIL reset_seg_sout: got %b want 1", seg_sout); end
        n_checks++; if (seg_pen !== 1'b0)  begin n_err++; $display("FAIL reset_seg_pen: got %b want 0", seg_pen); end
        n_checks++; if (seg_clrn !== 1'b0) begin n_err++; $display("FAIL reset_seg_clrn: got %b want 0", seg_clrn); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (seg_clrn !== 1'b1) begin n_err++; $display("FAIL release_seg_clrn: got %b want 1", seg_clrn); end
        n_checks++; if (busy !== 1'b0)     begin n_err++; $display("FAIL release_busy: got %b want 0", busy); end
    endtask

    task automatic test_decode();
        logic [63:0] bits;
        int bn, pn, pp, fr;
        logic s1, c1;
        do_frame(32'h01234567, 8'h00, 8'h00, -1, bits, bn, pn, pp, fr, s1, c1);
        n_checks++; if (bits !== 64'hC0F9A4B0999282F8) begin n_err++; $display("FAIL decode_bytes: got %h want c0f9a4b0999282f8", bits); end
        n_checks++; if (bn != 259) begin n_err++; $display("FAIL decode_busy_len: got %0d want 259", bn); end
        n_checks++; if (pn != 2)   begin n_err++; $display("FAIL decode_pen_len: got %0d want 2", pn); end
        n_checks++; if (pp != 1)   begin n_err++; $display("FAIL decode_pen_pulses: got %0d want 1", pp); end
        n_checks++; if (fr != 3)   begin n_err++; $display("FAIL decode_first_rise: got %0d want 3", fr); end
        n_checks++; if (s1 !== 1'b1 || c1 !== 1'b0) begin n_err++; $display("FAIL decode_first_bit: got sout=%b clk=%b want sout=1 clk=0", s1, c1); end
    endtask

    task automatic test_points();
        logic [63:0] bits;
        int bn, pn, pp, fr;
        logic s1, c1;
        do_frame(32'h89ABCDEF, 8'h81, 8'h00, -1, bits, bn, pn, pp, fr, s1, c1);
        n_checks++; if (bits !== 64'h00908883C6A1860E) begin n_err++; $display("FAIL points_bytes: got %h want 00908883c6a1860e", bits); end
        n_checks++; if (bn != 259) begin n_err++; $display("FAIL points_busy_len: got %0d want 259", bn); end
        n_checks++; if (s1 !== 1'b0) begin n_err++; $display("FAIL points_first_bit: got %b want 0", s1); end
    endtask

    task automatic test_blink();
        logic [63:0] bits;
        int bn, pn, pp, fr;
        logic s1, c1;
        // Start sampled at the 2nd edge after reset: blink counter 2, phase 0.
        apply_reset();
        repeat (1) @(negedge clk);
        do_frame(32'h89ABCDEF, 8'h00, 8'hFF, -1, bits, bn, pn, pp, fr, s1, c1);
        n_checks++; if (bits !== 64'h80908883C6A1868E) begin n_err++; $display("FAIL blink_phase0_bytes: got %h want 80908883c6a1868e", bits); end
        // Start sampled at the 10th edge after reset: blink counter 10, phase 1.
        apply_reset();
        repeat (9) @(negedge clk);
        do_frame(32'h01234567, 8'h11, 8'h0F, -1, bits, bn, pn, pp, fr, s1, c1);
        n_checks++; if (bits !== 64'hC0F9A430FFFFFFFF) begin n_err++; $display("FAIL blink_phase1_bytes: got %h want c0f9a430ffffffff", bits); end
        n_checks++; if (bn != 259) begin n_err++; $display("FAIL blink_busy_len: got %0d want 259", bn); end
    endtask

    task automatic test_repulse();
        logic [63:0] bits;
        int bn, pn, pp, fr;
        logic s1, c1;
        int seen;
        do_frame(32'h01234567, 8'h00, 8'h00, 50, bits, bn, pn, pp, fr, s1, c1);
        n_checks++; if (bn != 259) begin n_err++; $display("FAIL repulse_busy_len: got %0d want 259", bn); end
        n_checks++; if (pp != 1)   begin n_err++; $display("FAIL repulse_pen_pulses: got %0d want 1", pp); end
        n_checks++; if (bits !== 64'hC0F9A4B0999282F8) begin n_err++; $display("FAIL repulse_bytes: got %h want c0f9a4b0999282f8", bits); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy !== 1'b0) seen++;
            @(negedge clk);
        end
        n_checks++; if (seen != 0) begin n_err++; $display("FAIL repulse_not_queued: got %0d busy cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int wait_n, len1, gap, len2;
        hexs   = 32'h01234567;
        points = 8'h00;
        les    = 8'h00;
        start  = 1'b1;
        wait_n = 0;
        while (busy !== 1'b1 && wait_n < 10) begin @(negedge clk); wait_n++; end
        len1 = 0;
        while (busy === 1'b1 && len1 < 1000) begin @(negedge clk); len1++; end
        gap = 0;
        while (busy !== 1'b1 && gap < 10) begin @(negedge clk); gap++; end
        len2 = 0;
        start = 1'b0;
        while (busy === 1'b1 && len2 < 1000) begin @(negedge clk); len2++; end
        n_checks++; if (len1 != 259) begin n_err++; $display("FAIL b2b_len1: got %0d want 259", len1); end
        n_checks++; if (gap != 1)    begin n_err++; $display("FAIL b2b_idle_gap: got %0d want 1", gap); end
        n_checks++; if (len2 != 259) begin n_err++; $display("FAIL b2b_len2: got %0d want 259", len2); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int   rises, n, pen_seen, busy_seen;
        logic prev;
        hexs   = 32'h01234567;
        points = 8'h00;
        les    = 8'h00;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rises = 0;
        n     = 0;
        prev  = seg_clk;
        pen_seen = 0;
        while (rises < 20 && n < 500) begin
            @(negedge clk);
            n++;
            if (!prev && seg_clk) rises++;
            if (seg_pen) pen_seen++;
            prev = seg_clk;
        end
        n_checks++; if (rises != 20) begin n_err++; $display("FAIL midrst_reach_bit20: got %0d rises want 20", rises); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)     begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_checks++; if (seg_clk !== 1'b0)  begin n_err++; $display("FAIL midrst_seg_clk: got %b want 0", seg_clk); end
        n_checks++; if (seg_sout !== 1'b1) begin n_err++; $display("FAIL midrst_seg_sout: got %b want 1", seg_sout); end
        n_checks++; if (seg_clrn !== 1'b0) begin n_err++; $display("FAIL midrst_seg_clrn: got %b want 0", seg_clrn); end
        for (int i = 0; i < 3; i++) begin
            if (seg_pen) pen_seen++;
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (seg_clrn !== 1'b1) begin n_err++; $display("FAIL midrst_clrn_release: got %b want 1", seg_clrn); end
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (seg_pen) pen_seen++;
            if (busy) busy_seen++;
            @(negedge clk);
        end
        n_checks++; if (pen_seen != 0)  begin n_err++; $display("FAIL midrst_no_pen: got %0d pen cycles want 0", pen_seen); end
        n_checks++; if (busy_seen != 0) begin n_err++; $display("FAIL midrst_stays_idle: got %0d busy cycles want 0", busy_seen); end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        hexs   = '0;
        points = '0;
        les    = '0;
        @(negedge clk);
        test_reset();
        test_decode();
        test_points();
        test_blink();
        test_repulse();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sseg_serial_driver.md
# sseg_serial_driver

Downstream consumer of the 8-channel display multiplexer. It takes the selected 32-bit display word, the 8 decimal-point bits and the 8 blink-enable bits, and encodes them as eight 7-segment digit bytes. It then shifts the 64-bit frame serially into the board's external segment shift registers and finishes each frame with a latch strobe. One frame is sent per `start` request; tying `start` high gives continuous refresh.

## Interface
Parameters:
- `DIV`, default 2: shift-clock half-period in `clk` cycles; must be ≥1.
- `BLINK_W`, default 24: width of the free-running blink counter; its MSB is the blink phase.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous and active-high.
- `hexs` in 32: display word, 8 nibbles; nibble i = `hexs[4i+3:4i]` drives digit i.
- `points` in 8: decimal point per digit; 1 = dp lit.
- `les` in 8: blink enable per digit; 1 = digit blinks.
- `start` in 1: frame request, sampled only in IDLE.
- `busy` out 1: high while a frame is in progress.
- `seg_clk` out 1: shift clock to the external registers.
- `seg_sout` out 1: serial data.
- `seg_pen` out 1: latch/output-enable strobe.
- `seg_clrn` out 1: active-low clear to the external registers.

## Operation
- States: IDLE, LOAD, SHIFT, LATCH.
- IDLE:
  - `start`=1 → LOAD; otherwise stay in IDLE.
  - IDLE always lasts at least 1 cycle between frames.
- LOAD (1 cycle):
  - Snapshot `hexs`, `points`, `les` and the blink phase (`blink_cnt[BLINK_W-1]`).
  - Build the 64-bit frame: byte i = seg(nibble i), active-low {dp,g,f,e,d,c,b,a}; dp bit = ~points[i].
  - If les[i]=1 and the blink phase is 1, byte i = 8'hFF (blank, dp also off).
  - Frame order is byte 7 at [63:56] down to byte 0 at [7:0]; go to SHIFT.
- SHIFT:
  - 64 bits, MSB first (frame[63] first).
  - Each bit: `seg_sout` holds the bit; `seg_clk`=0 for DIV cycles, then 1 for DIV cycles.
  - The shift happens at the 1→0 transition of `seg_clk`. After bit 0's high phase → LATCH.
- LATCH: `seg_pen`=1 and `seg_clk`=0 for DIV cycles → IDLE.
- Segment table (active-low):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Blink counter: free-running, increments every cycle and wraps at 2^BLINK_W. It is not reset by `start`.
- `start` asserted while `busy`=1 is ignored; it is not queued.
- Input changes after LOAD do not affect the frame in flight.

## Timing
- Reset values: state IDLE, `busy`=0, `seg_clk`=0, `seg_sout`=1, `seg_pen`=0, `seg_clrn`=0 while `rst`=1, blink counter 0, frame register all ones.
- `seg_clrn`=1 from the first cycle after `rst` deasserts.
- All outputs are registered.
- `start` sampled at edge t → `busy`=1 at t+1 (LOAD).
- `seg_sout`=frame[63] at t+2 with `seg_clk`=0.
- First `seg_clk` rise at t+2+DIV.
- SHIFT lasts 128·DIV cycles; LATCH lasts DIV cycles.
- `busy` stays high for 1+129·DIV cycles: 259 for DIV=2.
- `seg_sout` is stable for the full high phase of `seg_clk`, giving setup DIV cycles and hold ≥1 cycle.
- `start` held high: the next LOAD begins exactly 1 IDLE cycle after `busy` falls.
- Reset mid-frame: the frame aborts on the next edge, all outputs take their reset values, and no `seg_pen` pulse is issued.
- Blink phase is sampled once per frame, so a frame is never partially blinked.

## Structure
- Package `sseg_pkg` holds:
  - the state enum;
  - the 16-entry segment constant table;
  - the blank constant 8'hFF.
- Sub-module `sseg_hex_decode`: a combinational nibble+dp → byte decoder, instantiated 8× in LOAD.
- The FSM, bit counter (6 bits), DIV phase counter and blink counter stay in the top level.

## Test plan
- Reset, then `hexs`=32'h01234567, `points`=0, `les`=0, `start` pulse, DIV=2:
  - captured serial bytes are C0 F9 A4 B0 99 92 82 F8;
  - `busy` high for 259 cycles;
  - one `seg_pen` pulse of 2 cycles.
- `hexs`=32'h89ABCDEF, `points`=8'h81:
  - bytes are 00 90 88 83 C6 A1 86 0E (dp cleared on digits 7 and 0).
- `les`=8'h0F with the blink counter forced to phase 1 (BLINK_W=4, start after 8 cycles):
  - bytes 3..0 = FF;
  - bytes 7..4 decode normally.
- `start` re-pulsed mid-frame: ignored, `busy` length unchanged.
- `start` held high: back-to-back frames separated by exactly 1 IDLE cycle.
- `rst` asserted at bit 20:
  - next cycle `busy`=0, `seg_clk`=0, `seg_sout`=1, `seg_clrn`=0;
  - no `seg_pen` pulse.
